axis_frame_source: RTL and testbench
====================================

# axis_frame_source

AXI-stream frame transmitter that feeds the stream convolver: on a start pulse it sends one kernel-select beat on a configuration stream. It then reads one image frame, word by word, from a synchronous frame RAM and sends it column-major on a pixel stream, marking the end of frame with a last flag. A 2-entry output FIFO with credit-based read issue absorbs the 1-cycle RAM latency and downstream backpressure while sustaining 1 word/cycle.

## Interface
- IMAGE_HEIGHT, 200, rows per column including zero padding; must be a multiple of PPW
- IMAGE_WIDTH, 200, columns per frame including padding
- NB_PIXEL, 8, bits per pixel
- DATA_WIDTH, 32, stream and RAM word width; PPW = DATA_WIDTH/NB_PIXEL pixels per word
- ADDR_WIDTH, 16, RAM word-address width; must hold FRAME_WORDS-1, where FRAME_WORDS = IMAGE_WIDTH*IMAGE_HEIGHT/PPW

Ports:
- i_clk  in  1  single clock; everything is on the rising edge
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  one-cycle frame start request
- i_kernel_sel  in  2  kernel select, latched on an accepted i_start
- o_busy  out  1  high from the cycle after an accepted start until the cycle after o_done
- o_done  out  1  one-cycle pulse after the last pixel beat is accepted
- o_mem_en  out  1  RAM read enable
- o_mem_addr  out  ADDR_WIDTH  RAM word address
- i_mem_data  in  DATA_WIDTH  RAM read data, valid the cycle after o_mem_en
- m1_axis_valid  out  1  configuration beat valid
- m1_axis_data  out  DATA_WIDTH  {zeros, kernel_sel[1:0]}
- m1_axis_ready  in  1  configuration sink ready
- m0_axis_valid  out  1  pixel beat valid
- m0_axis_data  out  DATA_WIDTH  PPW pixels; pixel i is in bits [i*NB_PIXEL +: NB_PIXEL]
- m0_axis_last  out  1  frame end marker; also column end when the macro below is defined
- m0_axis_ready  in  1  pixel sink ready

## Operation
- FSM states: IDLE, CFG, STREAM, DONE.
- IDLE
  - i_start is sampled only in IDLE; it is ignored in every other state.
  - An accepted start latches i_kernel_sel, clears the read address and beat counter, and moves to CFG.
- CFG
  - m1_axis_valid=1 and m1_axis_data={0, sel}.
  - On m1_axis_valid & m1_axis_ready, move to STREAM.
  - No RAM reads are issued in CFG.
- STREAM read issue
  - credits = 2 − fifo_count − inflight + pop, where pop = m0_axis_valid & m0_axis_ready.
  - Issue a read (o_mem_en=1, o_mem_addr=rd_addr, rd_addr+1) when credits>0 and rd_addr<FRAME_WORDS.
  - The read returning in cycle N+1 is pushed into the FIFO at the end of N+1.
- STREAM output
  - m0_axis_valid = FIFO non-empty; m0_axis_data = FIFO head.
  - m0_axis_last=1 on beat FRAME_WORDS−1.
  - The FIFO never overflows; simultaneous push and pop keeps the count unchanged.
- DONE
  - Entered on the cycle the final beat is accepted.
  - o_done=1 for one cycle, then back to IDLE.
- Output values
  - Data outputs hold their values when valid is low.
  - The AXI rule is honoured: once valid is asserted, data, last and valid stay stable until ready.
- Reset
  - Every output resets to 0; FSM goes to IDLE; FIFO, counters and inflight clear.
  - A RAM response arriving the cycle after reset is discarded.
  - Reset beats i_start in the same cycle.

## Timing
- Start accepted at cycle 0, m1_axis_ready held high:
  - cycle 1: CFG, m1_axis_valid=1
  - cycle 2: STREAM, first read issued
  - cycle 3: data pushed
  - cycle 4: m0_axis_valid=1
- With m0_axis_ready held high, one beat per cycle and no bubbles after the first.
- Last beat accepted at cycle T: o_done=1 at T+1; o_busy falls at T+2.
- m0_axis_ready low: at most 2 words are buffered and issue stops; throughput resumes the cycle ready returns.
- The RAM address wraps only by restarting at 0 on the next frame.

## Configuration
- STREAM_COL_LAST_EN
  - Defined: m0_axis_last also asserts on every beat whose index mod (IMAGE_HEIGHT/PPW) = IMAGE_HEIGHT/PPW − 1, i.e. per-column framing.
  - Undefined: m0_axis_last asserts only on beat FRAME_WORDS−1.

## Test plan
- Basic frame: H=8, W=2, RAM word k=k, start with sel=2, both readies held 1 -> m1 beat 0x00000002 at cycle 1; words 0,1,2,3 on cycles 4–7; last only on word 3; o_done at cycle 8.
- Pixel backpressure: m0_axis_ready toggles 1,0,1,0 -> beats 0..3 in order with no loss or duplication; data stable while stalled; o_mem_en never asserted when credits=0.
- Config stall: m1_axis_ready held 0 for 10 cycles -> no o_mem_en and m0_axis_valid=0 throughout; streaming starts 2 cycles after ready rises.
- Start while busy, and start with reset: i_start pulsed during STREAM -> ignored, frame unchanged; i_start and i_reset high together -> stays IDLE with all outputs 0.
- Reset mid-frame: i_reset after 2 beats accepted -> all outputs 0 next cycle; a new start replays from address 0 with sel re-latched.
- Macro: with STREAM_COL_LAST_EN, H=8, W=2 -> last on words 1 and 3; without the macro -> last on word 3 only.

Source files
------------

// File: rtl/axis_frame_source.sv
// AXI-stream frame source: one kernel-select config beat, then a RAM frame streamed column-major.
// Optional `STREAM_COL_LAST_EN adds a last flag at the end of every column.
module axis_frame_source #(
    parameter int unsigned IMAGE_HEIGHT = 200,
    parameter int unsigned IMAGE_WIDTH  = 200,
    parameter int unsigned NB_PIXEL     = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [1:0]            i_kernel_sel,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_mem_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  m1_axis_valid,
    output logic [DATA_WIDTH-1:0] m1_axis_data,
    input  logic                  m1_axis_ready,
    output logic                  m0_axis_valid,
    output logic [DATA_WIDTH-1:0] m0_axis_data,
    output logic                  m0_axis_last,
    input  logic                  m0_axis_ready
);
    localparam int unsigned PPW         = DATA_WIDTH / NB_PIXEL;
    localparam int unsigned FRAME_WORDS = IMAGE_WIDTH * IMAGE_HEIGHT / PPW;
    localparam logic [ADDR_WIDTH:0] FRAME_END = (ADDR_WIDTH+1)'(FRAME_WORDS);
    localparam logic [ADDR_WIDTH:0] LAST_IDX  = (ADDR_WIDTH+1)'(FRAME_WORDS - 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_CFG    = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]            state_q,    state_d;
    logic [1:0]            sel_q,      sel_d;
    logic [ADDR_WIDTH:0]   rd_addr_q,  rd_addr_d;
    logic [ADDR_WIDTH:0]   beat_q,     beat_d;
    logic                  inflight_q, inflight_d;
    logic [1:0]            cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0] head_q,     head_d;
    logic [DATA_WIDTH-1:0] skid_q,     skid_d;

    logic pop, push, issue, last_flag;

    assign push  = inflight_q;
    assign pop   = (cnt_q != 2'd0) & m0_axis_ready;
    // Reserve a FIFO slot for every read in flight; a pop this cycle frees one immediately.
    assign issue = (state_q == S_STREAM) && (rd_addr_q < FRAME_END) &&
                   (({1'b0, cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

`ifdef STREAM_COL_LAST_EN
    localparam int unsigned COL_WORDS = IMAGE_HEIGHT / PPW;
    localparam logic [ADDR_WIDTH:0] COL_END = (ADDR_WIDTH+1)'(COL_WORDS - 1);
    logic [ADDR_WIDTH:0] col_q, col_d;
    assign last_flag = (beat_q == LAST_IDX) || (col_q == COL_END);
`else
    assign last_flag = (beat_q == LAST_IDX);
`endif

    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE);
    assign o_mem_en      = issue;
    assign o_mem_addr    = rd_addr_q[ADDR_WIDTH-1:0];
    assign m1_axis_valid = (state_q == S_CFG);
    assign m1_axis_data  = {{(DATA_WIDTH-2){1'b0}}, sel_q};
    assign m0_axis_valid = (cnt_q != 2'd0);
    assign m0_axis_data  = head_q;
    assign m0_axis_last  = m0_axis_valid & last_flag;

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        rd_addr_d  = rd_addr_q;
        beat_d     = beat_q;
        inflight_d = issue;
        cnt_d      = cnt_q;
        head_d     = head_q;
        skid_d     = skid_q;
`ifdef STREAM_COL_LAST_EN
        col_d      = col_q;
`endif
        case (state_q)
            S_IDLE: if (i_start) begin
                state_d   = S_CFG;
                sel_d     = i_kernel_sel;
                rd_addr_d = '0;
                beat_d    = '0;
`ifdef STREAM_COL_LAST_EN
                col_d     = '0;
`endif
            end
            S_CFG:    if (m1_axis_ready) state_d = S_STREAM;
            S_STREAM: if (pop && (beat_q == LAST_IDX)) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        if (issue) rd_addr_d = rd_addr_q + CNT_ONE;
        if (pop) begin
            beat_d = beat_q + CNT_ONE;
`ifdef STREAM_COL_LAST_EN
            col_d  = (col_q == COL_END) ? '0 : col_q + CNT_ONE;
`endif
        end

        // Head register only changes on push/pop so the output holds while empty.
        case ({push, pop})
            2'b10: begin
                if (cnt_q == 2'd0) head_d = i_mem_data;
                else               skid_d = i_mem_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) head_d = skid_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = i_mem_data;
                end else begin
                    head_d = skid_q;
                    skid_d = i_mem_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            rd_addr_q  <= '0;
            beat_q     <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= '0;
            head_q     <= '0;
            skid_q     <= '0;
`ifdef STREAM_COL_LAST_EN
            col_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            rd_addr_q  <= rd_addr_d;
            beat_q     <= beat_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
`ifdef STREAM_COL_LAST_EN
            col_q      <= col_d;
`endif
        end
    end
endmodule

// File: tb/tb_axis_frame_source.sv
// Bench for axis_frame_source: directed timing checks plus randomized frames vs. a queue-level model.
module tb_axis_frame_source;
    localparam int unsigned H  = 8;
    localparam int unsigned W  = 2;
    localparam int unsigned NB = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 16;
    localparam int unsigned FW = W * H / (DW / NB);
    localparam int unsigned CW = H / (DW / NB);

    logic          clk = 1'b0;
    logic          i_reset, i_start;
    logic [1:0]    i_kernel_sel;
    logic          o_busy, o_done, o_mem_en;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] mem_data;
    logic          m1_axis_valid, m1_axis_ready;
    logic [DW-1:0] m1_axis_data;
    logic          m0_axis_valid, m0_axis_last, m0_axis_ready;
    logic [DW-1:0] m0_axis_data;

    logic [DW-1:0] ram [0:FW-1];

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    axis_frame_source #(
        .IMAGE_HEIGHT(H), .IMAGE_WIDTH(W), .NB_PIXEL(NB),
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_kernel_sel(i_kernel_sel),
        .o_busy(o_busy), .o_done(o_done), .o_mem_en(o_mem_en), .o_mem_addr(o_mem_addr),
        .i_mem_data(mem_data),
        .m1_axis_valid(m1_axis_valid), .m1_axis_data(m1_axis_data), .m1_axis_ready(m1_axis_ready),
        .m0_axis_valid(m0_axis_valid), .m0_axis_data(m0_axis_data), .m0_axis_last(m0_axis_last),
        .m0_axis_ready(m0_axis_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_mem_en) mem_data <= (o_mem_addr < AW'(FW)) ? ram[o_mem_addr[1:0]] : 32'hDEAD_BEEF;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_last(input int unsigned idx);
`ifdef STREAM_COL_LAST_EN
        return (idx == FW - 1) || (idx % CW == CW - 1);
`else
        return (idx == FW - 1);
`endif
    endfunction

    // Reference model: phase 0 idle, 1 config, 2 streaming, 3 done.
    int unsigned   mph = 0, acc = 0, iss = 0, frames = 0;
    logic [1:0]    msel = 2'd0;
    bit            rst_prev = 1'b1, prev_stall = 1'b0, prev_pop = 1'b0, pop_now;
    logic [DW-1:0] prev_data;
    bit            prev_last;

    always @(negedge clk) begin
        if (rst_prev) begin
            check("reset_ctrl", 64'({o_busy, o_done, o_mem_en, m1_axis_valid, m0_axis_valid, m0_axis_last}), 64'd0);
            check("reset_data", 64'({o_mem_addr, m1_axis_data, m0_axis_data}), 64'd0);
        end
        check("busy", 64'(o_busy), 64'(mph != 0));
        check("done", 64'(o_done), 64'(mph == 3));
        check("m1_valid", 64'(m1_axis_valid), 64'(mph == 1));
        check("m1_data", 64'(m1_axis_data), 64'(msel));
        if (mph != 2) begin
            check("m0_valid_outside_stream", 64'(m0_axis_valid), 64'd0);
            check("mem_en_outside_stream", 64'(o_mem_en), 64'd0);
        end
        if (m0_axis_valid) begin
            check("m0_data", 64'(m0_axis_data), (acc < FW) ? 64'(ram[acc]) : 'x);
            check("m0_last", 64'(m0_axis_last), 64'(exp_last(acc)));
        end else begin
            check("m0_last_without_valid", 64'(m0_axis_last), 64'd0);
        end
        if (prev_stall && !rst_prev) begin
            check("stall_valid", 64'(m0_axis_valid), 64'd1);
            check("stall_data", 64'(m0_axis_data), 64'(prev_data));
            check("stall_last", 64'(m0_axis_last), 64'(prev_last));
        end
        if (prev_pop && !rst_prev && mph == 2 && acc < FW)
            check("no_bubble", 64'(m0_axis_valid), 64'd1);

        pop_now = m0_axis_valid && m0_axis_ready;
        if (o_mem_en && mph == 2) begin
            check("mem_addr", 64'(o_mem_addr), 64'(iss));
            check("read_in_range", 64'(iss < FW), 64'd1);
            check("credit_limit", 64'((iss - acc - 32'(pop_now)) <= 1), 64'd1);
            iss++;
        end

        prev_stall = m0_axis_valid && !m0_axis_ready;
        prev_data  = m0_axis_data;
        prev_last  = m0_axis_last;
        prev_pop   = pop_now;
        if (pop_now) acc++;
        case (mph)
            0: if (i_start) begin mph = 1; msel = i_kernel_sel; acc = 0; iss = 0; end
            1: if (m1_axis_ready) mph = 2;
            2: if (pop_now && acc == FW) mph = 3;
            default: begin mph = 0; frames++; end
        endcase
        if (i_reset) begin mph = 0; msel = 2'd0; acc = 0; iss = 0; end
        rst_prev = i_reset;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int unsigned budget);
        for (int unsigned i = 0; i < budget && o_busy; i++) tick();
        check("idle_timeout", 64'(o_busy), 64'd0);
    endtask

    task automatic start_frame(input logic [1:0] sel);
        i_start = 1'b1;
        i_kernel_sel = sel;
        tick();
        i_start = 1'b0;
    endtask

    logic [3:0] last_pat;

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_kernel_sel = 2'd0;
        m1_axis_ready = 1'b1; m0_axis_ready = 1'b1;
        for (int unsigned k = 0; k < FW; k++) ram[k] = DW'(k);
`ifdef STREAM_COL_LAST_EN
        last_pat = 4'b1010;
`else
        last_pat = 4'b1000;
`endif
        repeat (3) tick();
        i_reset = 1'b0;
        tick();

        // Basic frame with exact cycle positions
        start_frame(2'd2);
        check("c1_m1_valid", 64'(m1_axis_valid), 64'd1);
        check("c1_m1_data", 64'(m1_axis_data), 64'h2);
        check("c1_busy", 64'(o_busy), 64'd1);
        check("c1_mem_en", 64'(o_mem_en), 64'd0);
        tick();
        check("c2_mem_en", 64'(o_mem_en), 64'd1);
        check("c2_mem_addr", 64'(o_mem_addr), 64'd0);
        check("c2_m0_valid", 64'(m0_axis_valid), 64'd0);
        tick();
        check("c3_m0_valid", 64'(m0_axis_valid), 64'd0);
        for (int unsigned k = 0; k < 4; k++) begin
            tick();
            check("beat_valid", 64'(m0_axis_valid), 64'd1);
            check("beat_data", 64'(m0_axis_data), 64'(k));
            check("beat_last", 64'(m0_axis_last), 64'(last_pat[k]));
        end
        tick();
        check("c8_done", 64'(o_done), 64'd1);
        check("c8_m0_valid", 64'(m0_axis_valid), 64'd0);
        tick();
        check("c9_busy", 64'(o_busy), 64'd0);
        check("c9_done", 64'(o_done), 64'd0);

        // Pixel backpressure: ready toggles every cycle
        start_frame(2'd3);
        for (int unsigned i = 0; i < 40 && o_busy; i++) begin
            m0_axis_ready = ~m0_axis_ready;
            tick();
        end
        m0_axis_ready = 1'b1;
        wait_idle(10);

        // Config stall
        m1_axis_ready = 1'b0;
        start_frame(2'd1);
        for (int unsigned i = 0; i < 10; i++) begin
            check("cfg_stall_mem_en", 64'(o_mem_en), 64'd0);
            check("cfg_stall_m0_valid", 64'(m0_axis_valid), 64'd0);
            check("cfg_stall_m1_valid", 64'(m1_axis_valid), 64'd1);
            tick();
        end
        m1_axis_ready = 1'b1;
        tick();
        check("cfg_release_mem_en", 64'(o_mem_en), 64'd1);
        tick();
        tick();
        check("cfg_release_m0_valid", 64'(m0_axis_valid), 64'd1);
        wait_idle(20);

        // Start while busy is ignored
        start_frame(2'd2);
        tick(); tick();
        start_frame(2'd0);
        check("busy_start_sel", 64'(m1_axis_data), 64'h2);
        wait_idle(20);
        check("busy_start_no_cfg", 64'(m1_axis_valid), 64'd0);

        // Start together with reset
        i_reset = 1'b1;
        start_frame(2'd1);
        i_reset = 1'b0;
        check("rst_start_busy", 64'(o_busy), 64'd0);
        tick();
        check("rst_start_stay_idle", 64'(o_busy), 64'd0);

        // Reset mid-frame, then replay with a new select
        for (int unsigned k = 0; k < FW; k++) ram[k] = $urandom;
        start_frame(2'd1);
        for (int unsigned i = 0; i < 30 && acc < 2; i++) tick();
        check("midframe_two_beats", 64'(acc >= 2), 64'd1);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("midframe_reset_busy", 64'(o_busy), 64'd0);
        check("midframe_reset_m0_valid", 64'(m0_axis_valid), 64'd0);
        start_frame(2'd3);
        check("replay_sel", 64'(m1_axis_data), 64'h3);
        wait_idle(30);

        // Randomized frames
        for (int unsigned f = 0; f < 40; f++) begin
            for (int unsigned k = 0; k < FW; k++) ram[k] = $urandom;
            m1_axis_ready = 1'($urandom_range(0, 1));
            start_frame(2'($urandom_range(0, 3)));
            for (int unsigned i = 0; i < 200 && o_busy; i++) begin
                m0_axis_ready = ($urandom_range(0, 2) != 0);
                m1_axis_ready = 1'($urandom_range(0, 1));
                i_start       = ($urandom_range(0, 7) == 0);
                i_kernel_sel  = 2'($urandom_range(0, 3));
                i_reset       = (f % 7 == 3) && ($urandom_range(0, 9) == 0);
                tick();
            end
            i_start = 1'b0;
            i_reset = 1'b0;
            check("rand_idle_timeout", 64'(o_busy), 64'd0);
            tick();
        end
        check("frames_completed_nonzero", 64'(frames > 10), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
